// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: IDLE/BUSY/DONE handshake with data memory.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned accesses instead of masking them.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mvalid,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [2:0]  mfunct3,
  input  logic [63:0] mr,
  input  logic [63:0] mb,
  output logic [63:0] md,
  output logic        mstall,
  output logic        mbuserr,
  output logic        mmisalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, nxt;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [2:0]  lane_q;
  logic        ld_q;

  logic [1:0]  size;
  logic [2:0]  amask;
  logic [2:0]  lane;
  logic [7:0]  strb;
  logic        cand;
  logic        legal;
  logic        access;
  logic        timeout;
  logic [63:0] sh;
  logic [63:0] ext;

  assign size = mfunct3[1:0];
  assign cand = mvalid & (mm2reg ^ mwmem) & (mfunct3 != 3'b111);

  always_comb begin
    amask = 3'b000;
    strb  = 8'h00;
    unique case (size)
      2'd0: begin amask = 3'b000; strb = 8'h01; end
      2'd1: begin amask = 3'b001; strb = 8'h03; end
      2'd2: begin amask = 3'b011; strb = 8'h0f; end
      2'd3: begin amask = 3'b111; strb = 8'hff; end
    endcase
  end

  // Low bits below the access size are dropped to land on a natural lane.
  assign lane = mr[2:0] & ~amask;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misal;
  assign misal     = |(mr[2:0] & amask);
  assign legal     = ~misal;
  assign mmisalign = ~rst & (state == IDLE) & cand & misal;
`else
  assign legal     = 1'b1;
  assign mmisalign = 1'b0;
`endif

  assign access  = cand & legal;
  assign timeout = (state == BUSY) & ~dmem_ack & (cnt == CNT_LAST);

  always_comb begin
    sh  = dmem_rdata >> {lane_q, 3'b000};
    ext = sh;
    unique case (f3_q)
      3'b000:  ext = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ext = {{32{sh[31]}}, sh[31:0]};
      3'b100:  ext = {56'd0, sh[7:0]};
      3'b101:  ext = {48'd0, sh[15:0]};
      3'b110:  ext = {32'd0, sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    mstall = 1'b0;
    unique case (state)
      IDLE: begin
        mstall = access;
        if (access) nxt = BUSY;
      end
      BUSY: begin
        mstall = 1'b1;
        if (dmem_ack || timeout) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (rst) mstall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      md         <= '0;
      mbuserr    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
      ld_q       <= 1'b0;
    end else begin
      mbuserr <= 1'b0;
      if (state == IDLE && access) begin
        cnt        <= '0;
        dmem_req   <= 1'b1;
        dmem_we    <= mwmem;
        dmem_addr  <= {mr[63:3], 3'b000};
        dmem_wdata <= mb << {lane, 3'b000};
        dmem_wstrb <= strb << lane;
        f3_q       <= mfunct3;
        lane_q     <= lane;
        ld_q       <= mm2reg;
      end else if (state == BUSY) begin
        if (dmem_ack || timeout) begin
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_addr  <= '0;
          dmem_wdata <= '0;
          dmem_wstrb <= '0;
        end
        if (dmem_ack) begin
          if (ld_q) md <= ext;
        end else if (timeout) begin
          mbuserr <= 1'b1;
          if (ld_q) md <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255 (legal 1..255): max cycles BUSY waits for dmem_ack before aborting.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mvalid  in  1  EX/MEM entry holds a live instruction.
REQ-005 mm2reg  in  1  instruction is a load.
REQ-006 mwmem  in  1  instruction is a store; mm2reg and mwmem both 1 = no access.
REQ-007 mfunct3  in  3  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-008 mr  in  64  effective byte address from execute.
REQ-009 mb  in  64  store data, value in low bits.
REQ-010 md  out  64  load result, extended to 64 bits, to MEM/WB.
REQ-011 mstall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; suppress MEM/WB write.
REQ-012 mbuserr  out  1  one-cycle pulse: access aborted by timeout.
REQ-013 mmisalign  out  1  one-cycle pulse: misaligned access rejected (see Configuration).
REQ-014 dmem_req, dmem_we  out  1 each  registered request and write-enable to data memory.
REQ-015 dmem_addr  out  64  doubleword-aligned address (bits [2:0] = 0).
REQ-016 dmem_wdata  out  64; dmem_wstrb  out  8  lane-shifted store data and byte strobes.
REQ-017 dmem_rdata  in  64; dmem_ack  in  1  read data and completion, valid in the same cycle.

Function
REQ-018 "Access" = mvalid & (mm2reg XOR mwmem) & mfunct3 != 111 & address legal; anything else makes no request, mstall 0.
REQ-019 FSM states IDLE, BUSY, DONE; IDLE+access -> BUSY; BUSY+dmem_ack -> DONE; BUSY+timeout -> DONE; DONE -> IDLE unconditionally.
REQ-020 mstall = (IDLE & access) | BUSY; 0 in DONE so the instruction advances exactly once and is never reissued.
REQ-021 dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb registered on IDLE->BUSY, held stable through BUSY, cleared on leaving BUSY.
REQ-022 Strobes: B one lane at mr[2:0], H two lanes at mr[2:1]*2, W four lanes at mr[2]*4, D all 8; wdata = mb shifted left by 8*lane offset.
REQ-023 On BUSY & dmem_ack with a load: md <= selected lanes, sign-extended (B,H,W) or zero-extended (BU,HU,WU, D untouched); stores leave md unchanged.
REQ-024 md holds its value until the next load completes; minimum load latency = 2 stall cycles, md valid in DONE.
REQ-025 Cycle counter cleared on entering BUSY, increments each BUSY cycle without ack; counter = TIMEOUT_CYCLES-1 and no ack -> DONE, md <= 0 for loads, mbuserr = 1 for the DONE cycle.
REQ-026 dmem_ack in the same cycle as timeout expiry: ack wins, no mbuserr.
REQ-027 dmem_ack while IDLE or DONE is ignored.

Reset
REQ-028 rst asserted: state IDLE, counter 0, md 0, dmem_req/dmem_we 0, dmem_addr/wdata/wstrb 0, mbuserr/mmisalign 0, mstall 0 during reset (async, no clock needed).
REQ-029 rst during BUSY abandons the access; no retry after release.

Configuration
REQ-030 Macro MEM_ACCESS_MISALIGN_TRAP_EN defined: access with mr not a multiple of size is illegal; no request, mstall 0, mmisalign = 1 for that cycle, md unchanged.
REQ-031 Macro undefined: mmisalign tied 0; address low bits masked to size alignment (H clears bit0, W bits[1:0], D bits[2:0]) and access proceeds.

Verification
REQ-032 LB mr=0x1003, dmem_rdata=0x00000000_80000000, ack 1 cycle after req -> dmem_wstrb n/a, md=0xFFFFFFFF_FFFFFF80, mstall high 2 cycles.
REQ-033 SH mr=0x2006, mb=0xABCD -> dmem_addr=0x2000, wstrb=0xC0, wdata[63:48]=0xABCD, dmem_we=1, md unchanged.
REQ-034 LWU mr=0x10, TIMEOUT_CYCLES=4, ack never -> BUSY exactly 4 cycles, mbuserr 1 cycle, md=0, mstall releases in DONE.
REQ-035 LD with ack arriving in final timeout cycle -> md=dmem_rdata, mbuserr stays 0.
REQ-036 LW mr=0x102: macro defined -> mmisalign pulse, no dmem_req; macro undefined -> dmem_addr=0x100, lanes 0-3 returned.
REQ-037 rst asserted mid-BUSY -> dmem_req, mstall drop immediately; after release next load starts from IDLE with counter 0.
